// File: rtl/rf_seq_pkg.sv
// Shared types for the register-to-register operation sequencer.
package rf_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_LI  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer: arithmetic modulo 2**W, carry/borrow flag.
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int unsigned W = 7
) (
    input  logic [2:0]   i_op,
    input  logic [W-1:0] i_op1,
    input  logic [W-1:0] i_op2,
    input  logic [W-1:0] i_imm,
    output logic [W-1:0] o_res,
    output logic         o_carry
);

    localparam int unsigned ShW = $clog2(W);

    logic [W:0]     w_sum;
    logic [W:0]     w_diff;
    logic [ShW-1:0] w_shamt;
    logic [31:0]    w_shamt32;
    logic           w_sh_over;

    assign w_sum     = {1'b0, i_op1} + {1'b0, i_op2};
    // Top bit of the extended difference is set exactly when op1 < op2.
    assign w_diff    = {1'b0, i_op1} - {1'b0, i_op2};
    assign w_shamt   = i_op2[ShW-1:0];
    assign w_shamt32 = 32'(w_shamt);
    assign w_sh_over = (w_shamt32 >= 32'(W));

    // Select the result and flag for the current opcode.
    always_comb begin
        o_res   = '0;
        o_carry = 1'b0;
        unique case (op_e'(i_op))
            OP_ADD: begin
                o_res   = w_sum[W-1:0];
                o_carry = w_sum[W];
            end
            OP_SUB: begin
                o_res   = w_diff[W-1:0];
                o_carry = w_diff[W];
            end
            OP_AND: o_res = i_op1 & i_op2;
            OP_OR:  o_res = i_op1 | i_op2;
            OP_XOR: o_res = i_op1 ^ i_op2;
            OP_SLL: o_res = w_sh_over ? '0 : (i_op1 << w_shamt);
            OP_SRL: o_res = w_sh_over ? '0 : (i_op1 >> w_shamt);
            OP_LI:  o_res = i_imm;
            default: begin
                o_res   = '0;
                o_carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rf_op_sequencer.sv
// Control/execute stage driving a 2**N x W register bank: read, execute, write back.
module rf_op_sequencer
    import rf_seq_pkg::*;
#(
    parameter int unsigned N = 5,
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_instr_valid,
    output logic         o_instr_ready,
    input  logic [2:0]   i_instr_op,
    input  logic [N-1:0] i_instr_rs1,
    input  logic [N-1:0] i_instr_rs2,
    input  logic [N-1:0] i_instr_rd,
    input  logic [W-1:0] i_instr_imm,
    output logic [N-1:0] o_addr_rs1,
    output logic [N-1:0] o_addr_rs2,
    output logic [N-1:0] o_addr_rd,
    output logic [W-1:0] o_data_out,
    output logic         o_we,
    input  logic [W:0]   i_rs1_data,
    input  logic [W:0]   i_rs2_data,
    output logic         o_done,
    output logic [W-1:0] o_result,
    output logic         o_flag_zero,
    output logic         o_flag_carry
);

    state_e       r_state;
    state_e       w_state_next;
    op_e          r_op;
    logic [N-1:0] r_rs1;
    logic [N-1:0] r_rs2;
    logic [N-1:0] r_rd;
    logic [W-1:0] r_imm;
    logic [W-1:0] r_op1;
    logic [W-1:0] r_op2;
    logic [W-1:0] r_alu_res;
    logic         r_alu_carry;
    logic [W-1:0] r_result;
    logic         r_zero;
    logic         r_carry;

    logic         w_accept;
    logic [W-1:0] w_res;
    logic         w_carry;
    logic         w_unused_msb;

    // The bank's read ports carry one spare bit that has no meaning here.
    assign w_unused_msb = i_rs1_data[W] ^ i_rs2_data[W];

    assign w_accept     = i_instr_valid && o_instr_ready;
    assign o_addr_rs1   = r_rs1;
    assign o_addr_rs2   = r_rs2;
    assign o_addr_rd    = r_rd;
    assign o_data_out   = r_alu_res;
    assign o_result     = r_result;
    assign o_flag_zero  = r_zero;
    assign o_flag_carry = r_carry;

    rf_seq_alu #(
        .W (W)
    ) u_alu (
        .i_op    (r_op),
        .i_op1   (r_op1),
        .i_op2   (r_op2),
        .i_imm   (r_imm),
        .o_res   (w_res),
        .o_carry (w_carry)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; LI has no operands so it skips the read cycle.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (op_e'(i_instr_op) == OP_LI) ? EXEC : READ;
                end
            end
            READ:    w_state_next = EXEC;
            EXEC:    w_state_next = WRITE;
            WRITE:   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Handshake and bank strobes; gated by rst so an abort never writes.
    always_comb begin
        o_instr_ready = (r_state == IDLE) && !rst;
        o_we          = (r_state == WRITE) && (r_rd != '0) && !rst;
        o_done        = (r_state == DONE) && !rst;
    end

    // Instruction latch, operand capture, execute register and reported result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= OP_ADD;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_alu_res   <= '0;
            r_alu_carry <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= op_e'(i_instr_op);
                r_rs1 <= i_instr_rs1;
                r_rs2 <= i_instr_rs2;
                r_rd  <= i_instr_rd;
                r_imm <= i_instr_imm;
            end
            // Bank read data is only valid while we is low, i.e. in READ.
            if (r_state == READ) begin
                r_op1 <= i_rs1_data[W-1:0];
                r_op2 <= i_rs2_data[W-1:0];
            end
            if (r_state == EXEC) begin
                r_alu_res   <= w_res;
                r_alu_carry <= w_carry;
            end
            if (r_state == WRITE) begin
                r_result <= r_alu_res;
                r_zero   <= (r_alu_res == '0);
                r_carry  <= r_alu_carry;
            end
        end
    end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Scoreboard bench for rf_op_sequencer with a behavioural register bank attached.
module tb_rf_op_sequencer;

    localparam int N = 5;
    localparam int W = 7;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int cyc;
        int res;
        int zero;
        int carry;
    } dn_t;

    logic         clk;
    logic         rst;
    logic         instr_valid;
    logic         instr_ready;
    logic [2:0]   instr_op;
    logic [N-1:0] instr_rs1;
    logic [N-1:0] instr_rs2;
    logic [N-1:0] instr_rd;
    logic [W-1:0] instr_imm;
    logic [N-1:0] addr_rs1;
    logic [N-1:0] addr_rs2;
    logic [N-1:0] addr_rd;
    logic [W-1:0] data_out;
    logic         we;
    logic [W:0]   rs1_data;
    logic [W:0]   rs2_data;
    logic         done;
    logic [W-1:0] result;
    logic         flag_zero;
    logic         flag_carry;

    logic [W-1:0] bank [32];
    logic         bank_clr;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    wr_t wr_q[$];
    dn_t dn_q[$];

    rf_op_sequencer #(
        .N (N),
        .W (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_instr_valid (instr_valid),
        .o_instr_ready (instr_ready),
        .i_instr_op    (instr_op),
        .i_instr_rs1   (instr_rs1),
        .i_instr_rs2   (instr_rs2),
        .i_instr_rd    (instr_rd),
        .i_instr_imm   (instr_imm),
        .o_addr_rs1    (addr_rs1),
        .o_addr_rs2    (addr_rs2),
        .o_addr_rd     (addr_rd),
        .o_data_out    (data_out),
        .o_we          (we),
        .i_rs1_data    (rs1_data),
        .i_rs2_data    (rs2_data),
        .o_done        (done),
        .o_result      (result),
        .o_flag_zero   (flag_zero),
        .o_flag_carry  (flag_carry)
    );

    // Register bank: r0 never written, reads forced to 0 during a write,
    // spare top read bit driven high so the sequencer must ignore it.
    always @(posedge clk) begin
        if (bank_clr) begin
            for (int i = 0; i < 32; i++) bank[i] <= '0;
        end else if (we && addr_rd != 0) begin
            bank[addr_rd] <= data_out;
        end
    end
    assign rs1_data = we ? '0 : {1'b1, bank[addr_rs1]};
    assign rs2_data = we ? '0 : {1'b1, bank[addr_rs2]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation on every write strobe and every done pulse.
    initial begin
        wr_t w;
        dn_t d;
        forever begin
            @(negedge clk);
            #1;
            if (we) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_we", int'(we), 0);
                end else begin
                    w = wr_q.pop_front();
                    check("we_cycle", cyc, w.cyc);
                    check("we_addr", int'(addr_rd), w.addr);
                    check("we_data", int'(data_out), w.data);
                end
            end
            if (done) begin
                if (dn_q.size() == 0) begin
                    check("unexpected_done", int'(done), 0);
                end else begin
                    d = dn_q.pop_front();
                    check("done_cycle", cyc, d.cyc);
                    check("result", int'(result), d.res);
                    check("flag_zero", int'(flag_zero), d.zero);
                    check("flag_carry", int'(flag_carry), d.carry);
                end
            end
        end
    end

    task automatic push_exp(input int t, input int op, input int rd, input int res, input int c);
        int lat;
        lat = (op == 7) ? 2 : 3;
        if (rd != 0) wr_q.push_back('{t + lat, rd, res});
        dn_q.push_back('{t + lat + 1, res, (res == 0) ? 1 : 0, c});
    endtask

    task automatic set_fields(input int op, input int rs1, input int rs2, input int rd,
                              input int imm);
        instr_op  = 3'(op);
        instr_rs1 = N'(rs1);
        instr_rs2 = N'(rs2);
        instr_rd  = N'(rd);
        instr_imm = W'(imm);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((wr_q.size() != 0 || dn_q.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", wr_q.size() + dn_q.size(), 0);
    endtask

    task automatic issue(input int op, input int rs1, input int rs2, input int rd,
                         input int imm, input int exp_res, input int exp_c);
        int n;
        @(negedge clk);
        set_fields(op, rs1, rs2, rd, imm);
        instr_valid = 1'b1;
        #1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!instr_ready) begin
            check("accept_timeout", int'(instr_ready), 1);
            instr_valid = 1'b0;
        end else begin
            push_exp(cyc, op, rd, exp_res, exp_c);
            @(negedge clk);
            instr_valid = 1'b0;
            wait_idle();
        end
    endtask

    initial begin
        int t;
        rst         = 1'b1;
        bank_clr    = 1'b1;
        instr_valid = 1'b0;
        set_fields(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        check("ready_in_rst", int'(instr_ready), 0);
        @(negedge clk);
        rst      = 1'b0;
        bank_clr = 1'b0;
        #1;
        check("rst_ready", int'(instr_ready), 1);
        check("rst_we", int'(we), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_flags", int'({flag_zero, flag_carry}), 0);
        check("rst_addr", int'({addr_rs1, addr_rs2, addr_rd}), 0);
        check("rst_data_out", int'(data_out), 0);

        // op, rs1, rs2, rd, imm, expected result, expected carry
        issue(7, 0, 0, 1, 8'h05, 8'h05, 0);   // LI  r1 = 0x05
        issue(7, 0, 0, 2, 8'h7C, 8'h7C, 0);   // LI  r2 = 0x7C
        issue(0, 1, 2, 3, 0, 8'h01, 1);       // ADD r3 = 5 + 124 = 129 mod 128
        issue(1, 1, 1, 4, 0, 8'h00, 0);       // SUB r4 = r1 - r1
        issue(1, 1, 2, 5, 0, 8'h09, 1);       // SUB r5 = 5 - 124 mod 128, borrow
        issue(5, 1, 1, 6, 0, 8'h20, 0);       // SLL r6 = 5 << 5 mod 128
        issue(7, 0, 0, 7, 8'h07, 8'h07, 0);   // LI  r7 = 7
        issue(6, 2, 7, 8, 0, 8'h00, 0);       // SRL r8 = r2 >> 7 (amount >= W)
        issue(0, 1, 2, 0, 0, 8'h01, 1);       // ADD r0: no write, done still pulses
        issue(2, 2, 5, 11, 0, 8'h08, 0);      // AND 0x7C & 0x09
        issue(3, 1, 2, 12, 0, 8'h7D, 0);      // OR  0x05 | 0x7C
        issue(4, 1, 2, 13, 0, 8'h79, 0);      // XOR 0x05 ^ 0x7C

        // Back-to-back: valid held high, second instruction waits for IDLE.
        @(negedge clk);
        set_fields(0, 1, 1, 9, 0);            // ADD r9 = 5 + 5
        instr_valid = 1'b1;
        #1;
        check("tp_ready_first", int'(instr_ready), 1);
        push_exp(cyc, 0, 9, 8'h0A, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) set_fields(6, 2, 1, 14, 0); // SRL r14 = 0x7C >> 5 = 3
            #1;
            check("tp_busy_ready", int'(instr_ready), 0);
        end
        @(negedge clk);
        #1;
        check("tp_ready_second", int'(instr_ready), 1);
        push_exp(cyc, 6, 14, 8'h03, 0);
        @(negedge clk);
        instr_valid = 1'b0;
        wait_idle();

        // Abort during EXEC: no write, IDLE next cycle, reported result cleared.
        @(negedge clk);
        set_fields(0, 1, 2, 10, 0);
        instr_valid = 1'b1;
        #1;
        check("abort_accept", int'(instr_ready), 1);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", int'(instr_ready), 1);
        check("abort_we", int'(we), 0);
        check("abort_done", int'(done), 0);
        check("abort_result", int'(result), 0);
        check("abort_flags", int'({flag_zero, flag_carry}), 0);
        repeat (6) @(negedge clk);
        issue(7, 0, 0, 15, 8'h33, 8'h33, 0);  // recovery after abort

        check("bank_r0", int'(bank[0]), 8'h00);
        check("bank_r1", int'(bank[1]), 8'h05);
        check("bank_r2", int'(bank[2]), 8'h7C);
        check("bank_r3", int'(bank[3]), 8'h01);
        check("bank_r5", int'(bank[5]), 8'h09);
        check("bank_r6", int'(bank[6]), 8'h20);
        check("bank_r9", int'(bank[9]), 8'h0A);
        check("bank_r10", int'(bank[10]), 8'h00);
        check("bank_r14", int'(bank[14]), 8'h03);
        check("bank_r15", int'(bank[15]), 8'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish by 100000");
        $fatal(1, "timeout");
    end

endmodule
